// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and handshake FSM state types.
// Used by the register slave and the bus interconnect.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } write_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } read_state_t;

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Combinational byte-address to register-index decode with range check.
// The low two address bits are ignored (word-granular registers).
module axi_lite_addr_decode #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-3:0] index,
  output logic                  hit
);

  localparam int unsigned IW = ADDR_WIDTH - 2;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [IW-1:0] BASE_WORD = IW'(BASE_ADDR >> 2);

  logic unused_low;
  assign unused_low = ^addr[1:0];

  // Base is word-aligned, so subtracting in word units equals (addr - base) >> 2.
  assign index = addr[ADDR_WIDTH-1:2] - BASE_WORD;
  assign hit   = (addr >= BASE) && (32'(index) < NUM_REGS);

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite slave exposing NUM_REGS byte-writable registers, with independent
// write (AW/W/B) and read (AR/R) state machines and a parallel register output.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESP_WIDTH = 3,
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                           s_axi_aclk,
  input  logic                           s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]          s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [RESP_WIDTH-1:0]          s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [RESP_WIDTH-1:0]          s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q
);

  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned IW = ADDR_WIDTH - 2;

  write_state_t wr_state, wr_next;
  read_state_t  rd_state, rd_next;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         wstrb_q;

  logic                  aw_hs, w_hs, ar_hs, wr_commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data, rd_word;
  logic [SW-1:0]         wr_strb;
  logic [IW-1:0]         wr_index, rd_index;
  logic                  wr_hit, rd_hit;
  logic                  unused_strb_top;

  assign unused_strb_top = s_axi_wstrb[SW];

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // Whichever half arrived earlier comes from its latch; the completing half is live.
  assign wr_addr = (wr_state == W_HAVE_ADDR) ? awaddr_q : s_axi_awaddr;
  assign wr_data = (wr_state == W_HAVE_DATA) ? wdata_q : s_axi_wdata;
  assign wr_strb = (wr_state == W_HAVE_DATA) ? wstrb_q : s_axi_wstrb[SW-1:0];

  axi_lite_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR)
  ) u_aw_decode (
    .addr (wr_addr),
    .index(wr_index),
    .hit  (wr_hit)
  );

  axi_lite_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR)
  ) u_ar_decode (
    .addr (s_axi_araddr),
    .index(rd_index),
    .hit  (rd_hit)
  );

  always_comb begin
    wr_next = wr_state;
    unique case (wr_state)
      W_IDLE: begin
        if (aw_hs && w_hs) wr_next = W_RESP;
        else if (aw_hs)    wr_next = W_HAVE_ADDR;
        else if (w_hs)     wr_next = W_HAVE_DATA;
      end
      W_HAVE_ADDR: if (w_hs)  wr_next = W_RESP;
      W_HAVE_DATA: if (aw_hs) wr_next = W_RESP;
      W_RESP:      if (s_axi_bvalid && s_axi_bready) wr_next = W_IDLE;
    endcase
  end

  assign wr_commit = (wr_next == W_RESP) && (wr_state != W_RESP);

  // Readies/valids are registered from the next state so they stay low through reset.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_state      <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= '0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
    end else begin
      wr_state      <= wr_next;
      s_axi_awready <= (wr_next == W_IDLE) || (wr_next == W_HAVE_DATA);
      s_axi_wready  <= (wr_next == W_IDLE) || (wr_next == W_HAVE_ADDR);
      s_axi_bvalid  <= (wr_next == W_RESP);
      if (aw_hs) awaddr_q <= s_axi_awaddr;
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb[SW-1:0];
      end
      if (wr_commit)
        s_axi_bresp <= wr_hit ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      regs <= '0;
    end else if (wr_commit && wr_hit) begin
      for (int unsigned r = 0; r < NUM_REGS; r++)
        for (int unsigned k = 0; k < SW; k++)
          if (wr_index == IW'(r) && wr_strb[k])
            regs[r][k*8 +: 8] <= wr_data[k*8 +: 8];
    end
  end

  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      R_IDLE: if (ar_hs) rd_next = R_DATA;
      R_DATA: if (s_axi_rvalid && s_axi_rready) rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++)
      if (rd_index == IW'(r)) rd_word = regs[r];
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rd_state      <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
    end else begin
      rd_state      <= rd_next;
      s_axi_arready <= (rd_next == R_IDLE);
      s_axi_rvalid  <= (rd_next == R_DATA);
      if (ar_hs) begin
        s_axi_rdata <= rd_hit ? rd_word : '0;
        s_axi_rresp <= rd_hit ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
      end
    end
  end

  assign regs_q = regs;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave: directed vector table, hand-built
// corner sequences, then randomized traffic against an array-based register model.
module tb_axi_lite_reg_slave;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RW = 3;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] awaddr;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic [DW/8:0] wstrb;
  logic          wvalid, wready;
  logic [RW-1:0] bresp;
  logic          bvalid, bready;
  logic [AW-1:0] araddr;
  logic          arvalid, arready;
  logic [DW-1:0] rdata;
  logic [RW-1:0] rresp;
  logic          rvalid, rready;
  logic [NR*DW-1:0] regs_q;

  axi_lite_reg_slave #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RESP_WIDTH(RW),
    .NUM_REGS  (NR),
    .BASE_ADDR (0)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .s_axi_awaddr (awaddr),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata  (wdata),
    .s_axi_wstrb  (wstrb),
    .s_axi_wvalid (wvalid),
    .s_axi_wready (wready),
    .s_axi_bresp  (bresp),
    .s_axi_bvalid (bvalid),
    .s_axi_bready (bready),
    .s_axi_araddr (araddr),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata  (rdata),
    .s_axi_rresp  (rresp),
    .s_axi_rvalid (rvalid),
    .s_axi_rready (rready),
    .regs_q       (regs_q)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  logic [31:0] model [NR];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_hit(input logic [7:0] addr);
    return (int'(addr) / 4) < NR;
  endfunction

  function automatic void model_write(input logic [7:0] addr, input logic [31:0] data,
                                      input logic [4:0] strb);
    if (model_hit(addr))
      for (int k = 0; k < 4; k++)
        if (strb[k]) model[int'(addr) / 4][k*8 +: 8] = data[k*8 +: 8];
  endfunction

  task automatic check_regs(input string name);
    for (int i = 0; i < NR; i++) check(name, regs_q[i*DW +: DW], model[i]);
  endtask

  // Call at a negedge; returns at a negedge with the B channel idle again.
  task automatic write_txn(input logic [7:0] addr, input logic [31:0] data, input logic [4:0] strb,
                           input int aw_dly, input int w_dly, input int hold,
                           input logic [2:0] exp_resp);
    bit aw_done = 0, w_done = 0, early_b = 0, aw_fire, w_fire;
    int cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      awaddr  = addr;
      wdata   = data;
      wstrb   = strb;
      awvalid = !aw_done && cyc >= aw_dly;
      wvalid  = !w_done && cyc >= w_dly;
      if (bvalid) early_b = 1;
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(negedge clk);
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done = 1;
      cyc++;
    end
    awvalid = 0;
    wvalid  = 0;
    check("wr_handshake_done", {62'd0, aw_done, w_done}, 64'd3);
    check("b_not_early", early_b, 0);
    check("b_latency", bvalid, 1);
    check("bresp", bresp, exp_resp);
    model_write(addr, data, strb);
    check_regs("regs_after_write");
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("b_hold_valid", bvalid, 1);
      check("b_hold_resp", bresp, exp_resp);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    check("b_drop", bvalid, 0);
  endtask

  task automatic read_txn(input logic [7:0] addr, input int ar_dly, input int hold,
                          input logic [31:0] exp_data, input logic [2:0] exp_resp);
    bit ar_done = 0, ar_fire;
    int cyc = 0;
    while (!ar_done && cyc < 40) begin
      araddr  = addr;
      arvalid = cyc >= ar_dly;
      ar_fire = arvalid && arready;
      @(negedge clk);
      if (ar_fire) ar_done = 1;
      cyc++;
    end
    arvalid = 0;
    check("rd_handshake_done", ar_done, 1);
    check("r_latency", rvalid, 1);
    check("rdata", rdata, exp_data);
    check("rresp", rresp, exp_resp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("r_hold_valid", rvalid, 1);
      check("r_hold_data", rdata, exp_data);
      check("r_hold_resp", rresp, exp_resp);
    end
    rready = 1;
    @(negedge clk);
    rready = 0;
    check("r_drop", rvalid, 0);
  endtask

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [4:0]  strb;
    int          d1;
    int          d2;
    int          hold;
    logic [31:0] exp_data;
    logic [2:0]  exp_resp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  a;
    logic [31:0] d, old1;
    logic [4:0]  s;

    // d1/d2 = AW/W delay for writes, d1 = AR delay for reads; hold = cycles of backpressure
    vecs.push_back('{1, 8'h04, 32'hDEADBEEF, 5'h0F, 0, 0, 0, 32'h0, 3'd0});
    vecs.push_back('{1, 8'h08, 32'h11223344, 5'h0F, 3, 0, 4, 32'h0, 3'd0});
    vecs.push_back('{1, 8'h00, 32'hFFFFFFFF, 5'h0F, 0, 0, 0, 32'h0, 3'd0});
    vecs.push_back('{1, 8'h00, 32'h00000000, 5'h05, 0, 1, 0, 32'h0, 3'd0});
    vecs.push_back('{0, 8'h00, 32'h0, 5'h0, 0, 0, 0, 32'hFF00FF00, 3'd0});
    vecs.push_back('{1, 8'h0C, 32'hCAFEF00D, 5'h0F, 0, 0, 1, 32'h0, 3'd0});
    vecs.push_back('{0, 8'h0C, 32'h0, 5'h0, 0, 0, 3, 32'hCAFEF00D, 3'd0});
    vecs.push_back('{0, 8'h10, 32'h0, 5'h0, 1, 0, 0, 32'h00000000, 3'd2});
    vecs.push_back('{1, 8'h20, 32'h99999999, 5'h0F, 0, 0, 2, 32'h0, 3'd2});
    vecs.push_back('{1, 8'h0C, 32'h12345678, 5'h00, 0, 0, 0, 32'h0, 3'd0});
    vecs.push_back('{1, 8'h0C, 32'h12345678, 5'h10, 0, 0, 0, 32'h0, 3'd0});
    vecs.push_back('{0, 8'h0C, 32'h0, 5'h0, 0, 0, 0, 32'hCAFEF00D, 3'd0});
    vecs.push_back('{1, 8'h07, 32'h00000055, 5'h01, 2, 2, 0, 32'h0, 3'd0});
    vecs.push_back('{0, 8'h04, 32'h0, 5'h0, 2, 0, 0, 32'hDEADBE55, 3'd0});
    vecs.push_back('{0, 8'h08, 32'h0, 5'h0, 0, 0, 0, 32'h11223344, 3'd0});
    vecs.push_back('{0, 8'hFC, 32'h0, 5'h0, 0, 0, 0, 32'h00000000, 3'd2});

    for (int i = 0; i < NR; i++) model[i] = '0;
    rst_n = 0; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;

    repeat (2) @(negedge clk);
    check("reset_awready", awready, 0);
    check("reset_regs", regs_q, 0);
    rst_n = 1;
    #1 check("release_ready_still_low", {awready, wready, arready}, 0);
    @(negedge clk);
    check("ready_after_release", {awready, wready, arready}, 3'b111);
    check("valids_after_release", {bvalid, rvalid}, 0);

    foreach (vecs[i]) begin
      if (vecs[i].is_wr)
        write_txn(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].d1, vecs[i].d2,
                  vecs[i].hold, vecs[i].exp_resp);
      else
        read_txn(vecs[i].addr, vecs[i].d1, vecs[i].hold, vecs[i].exp_data, vecs[i].exp_resp);
    end

    // missing write alongside an independent read of register 0
    fork
      write_txn(8'h20, 32'h5A5A5A5A, 5'h0F, 0, 0, 1, 3'd2);
      read_txn(8'h00, 0, 1, model[0], 3'd0);
    join

    // read and write of the same register on one edge: read sees the old value
    old1 = model[1];
    awaddr = 8'h04; wdata = 32'h0BADC0DE; wstrb = 5'h0F; araddr = 8'h04;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    model_write(8'h04, 32'h0BADC0DE, 5'h0F);
    check("collide_rvalid", rvalid, 1);
    check("collide_rdata_old", rdata, old1);
    check("collide_bvalid", bvalid, 1);
    check_regs("collide_regs_new");
    bready = 1; rready = 1;
    @(negedge clk);
    bready = 0; rready = 0;

    // valids dropped without handshake leave no trace
    awaddr = 8'h00; awvalid = 1; #1 awvalid = 0;
    @(negedge clk);
    check("abandoned_aw_no_b", bvalid, 0);
    read_txn(8'h00, 0, 0, model[0], 3'd0);

    // randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 9) == 0) ? 8'(32'hF0 + $urandom_range(0, 15))
                                      : 8'($urandom_range(0, 23));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 5'($urandom_range(0, 31));
        write_txn(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                  model_hit(a) ? 3'd0 : 3'd2);
      end else begin
        read_txn(a, $urandom_range(0, 3), $urandom_range(0, 2),
                 model_hit(a) ? model[int'(a) / 4] : 32'h0, model_hit(a) ? 3'd0 : 3'd2);
      end
    end

    // asynchronous reset while a response is pending
    awaddr = 8'h04; wdata = 32'h77777777; wstrb = 5'h0F;
    awvalid = 1; wvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    check("pre_reset_bvalid", bvalid, 1);
    #2 rst_n = 0;
    #1;
    check("async_reset_bvalid", bvalid, 0);
    check("async_reset_readies", {awready, wready, arready}, 0);
    check("async_reset_regs", regs_q, 0);
    for (int i = 0; i < NR; i++) model[i] = '0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("post_reset_ready", {awready, wready, arready}, 3'b111);
    check("post_reset_no_b", bvalid, 0);
    read_txn(8'h04, 0, 0, 32'h0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
